integrator_comb_decim: RTL

- Decimating comb (differentiator) stage directly downstream of the integrator top entity.
- Consumes the integrator's signed 10-bit running sum, keeps every R-th valid sample, and outputs the difference against the sample taken M decimated steps earlier.
- Integrator plus this block form a single-stage CIC decimator.
- All arithmetic is modulo 2^W, so integrator wrap-around cancels exactly.

---
 rtl/integrator_pkg.sv | 15 +
 rtl/integrator_decim_ctr.sv | 41 ++++
 rtl/integrator_comb_decim.sv | 61 ++++++
 3 files changed

// File: rtl/integrator_pkg.sv
// Shared constants and types for the integrator and its decimating comb stage.
package integrator_pkg;

  localparam int SAMPLE_W  = 10;
  localparam int DEFAULT_R = 4;
  localparam int DEFAULT_M = 1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    COUNTING,
    TAKE
  } phase_state_t;

endpackage

// File: rtl/integrator_decim_ctr.sv
// Decimation phase counter: counts valid samples and strobes take on every R-th one.
module integrator_decim_ctr
  import integrator_pkg::*;
#(
  parameter int R = DEFAULT_R
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic take
);

  localparam int CTR_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [CTR_W-1:0] LAST = CTR_W'(R - 1);

  logic [CTR_W-1:0] phase;
  logic [CTR_W-1:0] phase_next;
  phase_state_t     state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= '0;
    else     phase <= phase_next;
  end

  // Invalid cycles leave the phase untouched so stalls do not count as samples.
  always_comb begin
    state      = COUNTING;
    phase_next = phase;
    if (in_valid) begin
      if (phase == LAST) begin
        state      = TAKE;
        phase_next = '0;
      end else begin
        phase_next = phase + 1'b1;
      end
    end
  end

  assign take = (state == TAKE);

endmodule

// File: rtl/integrator_comb_decim.sv
// Decimating comb stage of a single-stage CIC: out = take sample minus the take M steps back.
// Optional extra output register stage: define INTEGRATOR_COMB_OUTREG_EN.
module integrator_comb_decim
  import integrator_pkg::*;
#(
  parameter int W = SAMPLE_W,
  parameter int R = DEFAULT_R,
  parameter int M = DEFAULT_M
) (
  input  logic                system1000,
  input  logic                system1000_rst,
  input  logic signed [W-1:0] in_data,
  input  logic                in_valid,
  output logic signed [W-1:0] out_data,
  output logic                out_valid
);

  logic                take;
  logic signed [W-1:0] delay [M];
  logic signed [W-1:0] comb_data;
  logic                comb_valid;

  integrator_decim_ctr #(.R(R)) u_ctr (
    .clk      (system1000),
    .rst      (system1000_rst),
    .in_valid (in_valid),
    .take     (take)
  );

  // Modulo-2^W subtraction lets integrator wrap-around cancel exactly.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      for (int k = 0; k < M; k++) delay[k] <= '0;
      comb_data  <= '0;
      comb_valid <= 1'b0;
    end else begin
      comb_valid <= take;
      if (take) begin
        comb_data <= in_data - delay[M-1];
        delay[0]  <= in_data;
        for (int k = M - 1; k > 0; k--) delay[k] <= delay[k-1];
      end
    end
  end

`ifdef INTEGRATOR_COMB_OUTREG_EN
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_data  <= comb_data;
      out_valid <= comb_valid;
    end
  end
`else
  assign out_data  = comb_data;
  assign out_valid = comb_valid;
`endif

endmodule
